hybrid_adder_bram: RTL and testbench

HYBRID_ADDER_BRAM -- requirements
Module: hybrid_adder_bram

---
 rtl/hybrid_adder_bram_pkg.sv | 40 ++++
 rtl/hybrid_adder_bram_hybrid_adder.sv | 51 +++++
 rtl/hybrid_adder_bram.sv | 125 ++++++++++++
 tb/tb_hybrid_adder_bram.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hybrid_adder_bram_pkg.sv
// -----------------------------------------------------------------------------
// hybrid_adder_bram_pkg
// Shared defaults for the neighbourhood-pixel BRAM block.
//   DEFAULT_DEPTH / DEFAULT_WIDTH / DEFAULT_AW : memory geometry defaults
//   *_MSB                                      : top bit of each 8-bit field
//   f_field                                    : extract one 8-bit field
//   f_div3                                     : exact floor(x/3) for x = 0..765
// -----------------------------------------------------------------------------
package hybrid_adder_bram_pkg;

   localparam int DEFAULT_DEPTH = 18400;
   localparam int DEFAULT_WIDTH = 96;
   localparam int DEFAULT_AW    = 15;

   localparam int GRAY_MSB      = 95;
   localparam int LEFT_MSB      = 87;
   localparam int RIGHT_MSB     = 79;
   localparam int UP_MSB        = 71;
   localparam int DOWN_MSB      = 63;
   localparam int LEFTUP_MSB    = 55;
   localparam int LEFTDOWN_MSB  = 47;
   localparam int RIGHTUP_MSB   = 39;
   localparam int RIGHTDOWN_MSB = 31;
   localparam int BLUE_MSB      = 23;
   localparam int GREEN_MSB     = 15;
   localparam int RED_MSB       = 7;

   function automatic logic [7:0] f_field(input logic [95:0] word, input int msb);
      return word[msb -: 8];
   endfunction

   // x*683/2048 overshoots x/3 by x/6144, which stays below the 1/3 slack
   // left by the remainder for every x up to 765, so the floor is exact.
   function automatic logic [7:0] f_div3(input logic [9:0] x);
      logic [19:0] p;
      p = {10'd0, x} * 20'd683;
      return p[18:11];
   endfunction

endpackage

// File: rtl/hybrid_adder_bram_hybrid_adder.sv
// -----------------------------------------------------------------------------
// hybrid_adder
// N-bit adder: ripple-carry low half, carry-select high half.
//   i_a, i_b : operands (N bits)
//   i_cin    : carry in
//   o_sum    : N-bit sum
//   o_cout   : carry out
// -----------------------------------------------------------------------------
module hybrid_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_cin,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   localparam int LO = N / 2;
   localparam int HI = N - LO;

   logic [LO-1:0] w_sum_lo;
   logic          w_c_lo;
   logic [HI-1:0] w_a_hi;
   logic [HI-1:0] w_b_hi;
   logic [HI:0]   w_hi0;
   logic [HI:0]   w_hi1;

   // Ripple-carry chain over the low half
   always_comb begin : ripple_lo
      logic c;
      c        = i_cin;
      w_sum_lo = '0;
      for (int k = 0; k < LO; k++) begin
         w_sum_lo[k] = i_a[k] ^ i_b[k] ^ c;
         c           = (i_a[k] & i_b[k]) | (c & (i_a[k] ^ i_b[k]));
      end
      w_c_lo = c;
   end

   assign w_a_hi = i_a[N-1:LO];
   assign w_b_hi = i_b[N-1:LO];

   // Both high-half results are formed in parallel; the low carry picks one
   assign w_hi0 = {1'b0, w_a_hi} + {1'b0, w_b_hi};
   assign w_hi1 = {1'b0, w_a_hi} + {1'b0, w_b_hi} + {{HI{1'b0}}, 1'b1};

   assign o_sum  = {(w_c_lo ? w_hi1[HI-1:0] : w_hi0[HI-1:0]), w_sum_lo};
   assign o_cout = w_c_lo ? w_hi1[HI] : w_hi0[HI];

endmodule

// File: rtl/hybrid_adder_bram.sv
// -----------------------------------------------------------------------------
// hybrid_adder_bram
// Single-port read-first block RAM of 96-bit pixel-neighbourhood words, with
// sum3 = up + leftup + rightup of the read word and a registered average.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_en, i_we      : access enable, write enable (qualified by i_en)
//   i_addr, i_din   : word address, write data
//   o_dout          : registered read data (zeros for out-of-range reads)
//   o_dout_valid    : o_dout comes from an enabled access
//   o_sum3          : combinational three-field sum of o_dout
//   o_avg, o_gray4  : floor(sum3/3) and its upper nibble, one cycle later
//   o_avg_valid     : o_dout_valid delayed one cycle
// -----------------------------------------------------------------------------
module hybrid_adder_bram
   import hybrid_adder_bram_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int AW    = DEFAULT_AW
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_dout_valid,
   output logic [9:0]       o_sum3,
   output logic [7:0]       o_avg,
   output logic [3:0]       o_gray4,
   output logic             o_avg_valid
);

   localparam logic [AW-1:0] LP_DEPTH_A = AW'(DEPTH);

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_valid;
   logic [7:0]       r_avg;
   logic [3:0]       r_gray4;
   logic             r_avg_valid;

   logic             w_in_range;
   logic [7:0]       w_up;
   logic [7:0]       w_leftup;
   logic [7:0]       w_rightup;
   logic [7:0]       w_s1_sum;
   logic             w_s1_cout;
   logic [8:0]       w_s2_sum;
   logic             w_s2_cout;
   logic [9:0]       w_sum3;
   logic [7:0]       w_avg;

   assign w_in_range = (i_addr < LP_DEPTH_A);

   // Array write; no reset so the array maps onto block RAM
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_en && i_we && w_in_range) begin
         r_mem[i_addr] <= i_din;
      end
   end

   // Read port: read-first, so a write cycle returns the old word
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else if (i_en) begin
         r_dout_valid <= 1'b1;
         if (w_in_range) begin
            r_dout <= r_mem[i_addr];
         end else begin
            r_dout <= '0;
         end
      end else begin
         r_dout_valid <= 1'b0;
      end
   end

   assign w_up      = f_field(r_dout, UP_MSB);
   assign w_leftup  = f_field(r_dout, LEFTUP_MSB);
   assign w_rightup = f_field(r_dout, RIGHTUP_MSB);

   hybrid_adder #(.N(8)) u_stage1 (
      .i_a    (w_up),
      .i_b    (w_leftup),
      .i_cin  (1'b0),
      .o_sum  (w_s1_sum),
      .o_cout (w_s1_cout)
   );

   // Stage-1 carry becomes bit 8 of the operand, i.e. weight 256
   hybrid_adder #(.N(9)) u_stage2 (
      .i_a    ({w_s1_cout, w_s1_sum}),
      .i_b    ({1'b0, w_rightup}),
      .i_cin  (1'b0),
      .o_sum  (w_s2_sum),
      .o_cout (w_s2_cout)
   );

   assign w_sum3 = {w_s2_cout, w_s2_sum};
   assign w_avg  = f_div3(w_sum3);

   // Average stage, one cycle behind the read data
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_avg       <= 8'd0;
         r_gray4     <= 4'd0;
         r_avg_valid <= 1'b0;
      end else begin
         r_avg       <= w_avg;
         r_gray4     <= w_avg[7:4];
         r_avg_valid <= r_dout_valid;
      end
   end

   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_valid;
   assign o_sum3       = w_sum3;
   assign o_avg        = r_avg;
   assign o_gray4      = r_gray4;
   assign o_avg_valid  = r_avg_valid;

endmodule

// File: tb/tb_hybrid_adder_bram.sv
// -----------------------------------------------------------------------------
// tb_hybrid_adder_bram
// Directed vectors with hand-computed expectations for hybrid_adder_bram.
// -----------------------------------------------------------------------------
module tb_hybrid_adder_bram;

   logic        clk;
   logic        rst;
   logic        en;
   logic        we;
   logic [14:0] addr;
   logic [95:0] din;
   logic [95:0] dout;
   logic        dout_valid;
   logic [9:0]  sum3;
   logic [7:0]  avg;
   logic [3:0]  gray4;
   logic        avg_valid;

   int n_checks = 0;
   int n_errors = 0;

   hybrid_adder_bram dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .i_we         (we),
      .i_addr       (addr),
      .i_din        (din),
      .o_dout       (dout),
      .o_dout_valid (dout_valid),
      .o_sum3       (sum3),
      .o_avg        (avg),
      .o_gray4      (gray4),
      .o_avg_valid  (avg_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one access, clock it, and settle just after the edge
   task automatic acc(input logic e, input logic w, input logic [14:0] a, input logic [95:0] d);
      en   = e;
      we   = w;
      addr = a;
      din  = d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [95:0] mk(input logic [7:0] up, input logic [7:0] lu,
                                      input logic [7:0] ru, input logic [7:0] other);
      logic [95:0] w;
      w        = {12{other}};
      w[71:64] = up;
      w[55:48] = lu;
      w[39:32] = ru;
      return w;
   endfunction

   function automatic logic [95:0] stream_word(input int i);
      logic [95:0] w;
      w        = mk(8'(10 * i + 1), 8'(20 * i + 2), 8'(25 * i + 3), 8'h00);
      w[95:88] = 8'(i);
      w[7:0]   = 8'(8'hA0 + i);
      return w;
   endfunction

   function automatic int stream_avg(input int i);
      return ((10 * i + 1) + (20 * i + 2) + (25 * i + 3)) / 3;
   endfunction

   logic [95:0] w1, w2, p0, p1, wa, wb;

   initial begin
      rst = 1'b1; en = 1'b0; we = 1'b0; addr = 15'd0; din = 96'd0;
      w1 = mk(8'h30, 8'h60, 8'h90, 8'h00);
      w2 = mk(8'hFF, 8'hFF, 8'hFE, 8'h00);
      p0 = 96'h0123_4567_89AB_CDEF_1357_9BDF;
      p1 = 96'hFEDC_BA98_7654_3210_2468_ACE0;
      wa = 96'hAAAA_0000_1111_2222_3333_4444;
      wb = 96'hBBBB_5555_6666_7777_8888_9999;

      // Reset state; the access presented during reset is discarded
      acc(1'b1, 1'b1, 15'd5, {12{8'hFF}});
      acc(1'b1, 1'b0, 15'd5, 96'd0);
      check_eq("rst_dout",  dout, 96'd0);
      check_eq("rst_dv",    96'(dout_valid), 96'd0);
      check_eq("rst_avg",   96'(avg), 96'd0);
      check_eq("rst_gray4", 96'(gray4), 96'd0);
      check_eq("rst_av",    96'(avg_valid), 96'd0);
      rst = 1'b0;

      // Basic write then read of addr 5
      acc(1'b1, 1'b1, 15'd5, w1);
      acc(1'b1, 1'b0, 15'd5, 96'd0);
      check_eq("rd5_dout", dout, w1);
      check_eq("rd5_dv",   96'(dout_valid), 96'd1);
      check_eq("rd5_sum3", 96'(sum3), 96'd288);
      acc(1'b0, 1'b0, 15'd0, 96'd0);
      check_eq("rd5_avg",   96'(avg), 96'h60);
      check_eq("rd5_gray4", 96'(gray4), 96'h6);
      check_eq("rd5_av",    96'(avg_valid), 96'd1);
      check_eq("idle_dv",   96'(dout_valid), 96'd0);
      check_eq("idle_hold", dout, w1);

      // Saturating sums
      acc(1'b1, 1'b1, 15'd1, {12{8'hFF}});
      acc(1'b1, 1'b1, 15'd2, w2);
      acc(1'b1, 1'b0, 15'd1, 96'd0);
      check_eq("ff_sum3", 96'(sum3), 96'd765);
      acc(1'b1, 1'b0, 15'd2, 96'd0);
      check_eq("ff_avg",    96'(avg), 96'hFF);
      check_eq("ff_gray4",  96'(gray4), 96'hF);
      check_eq("fe_sum3",   96'(sum3), 96'd764);
      acc(1'b0, 1'b0, 15'd0, 96'd0);
      check_eq("fe_avg",    96'(avg), 96'd254);
      check_eq("fe_gray4",  96'(gray4), 96'hF);

      // Out-of-range address; back-to-back reads of the end words
      acc(1'b1, 1'b1, 15'd0, p0);
      acc(1'b1, 1'b1, 15'd18399, p1);
      acc(1'b1, 1'b1, 15'd18400, 96'd1);
      check_eq("oor_wr_dout", dout, 96'd0);
      check_eq("oor_wr_dv",   96'(dout_valid), 96'd1);
      acc(1'b1, 1'b0, 15'd18400, 96'd0);
      check_eq("oor_rd_dout", dout, 96'd0);
      check_eq("oor_rd_dv",   96'(dout_valid), 96'd1);
      acc(1'b1, 1'b0, 15'd18399, 96'd0);
      check_eq("top_dout", dout, p1);
      acc(1'b1, 1'b0, 15'd0, 96'd0);
      check_eq("zero_dout", dout, p0);
      check_eq("zero_dv",   96'(dout_valid), 96'd1);

      // Read-first on write collision
      acc(1'b1, 1'b1, 15'd7, wa);
      acc(1'b1, 1'b1, 15'd7, wb);
      check_eq("rf_old", dout, wa);
      acc(1'b1, 1'b0, 15'd7, 96'd0);
      check_eq("rf_new", dout, wb);

      // Streaming reads with a reset pulse mid-stream
      for (int i = 0; i < 10; i++) acc(1'b1, 1'b1, 15'(i), stream_word(i));
      acc(1'b1, 1'b0, 15'd0, 96'd0);
      check_eq("st0_dout", dout, stream_word(0));
      for (int i = 1; i < 3; i++) begin
         acc(1'b1, 1'b0, 15'(i), 96'd0);
         check_eq("st_dout", dout, stream_word(i));
         check_eq("st_avg",  96'(avg), 96'(stream_avg(i - 1)));
         check_eq("st_av",   96'(avg_valid), 96'd1);
      end
      rst = 1'b1;
      acc(1'b1, 1'b0, 15'd3, 96'd0);
      rst = 1'b0;
      check_eq("mr_dout",  dout, 96'd0);
      check_eq("mr_dv",    96'(dout_valid), 96'd0);
      check_eq("mr_avg",   96'(avg), 96'd0);
      check_eq("mr_gray4", 96'(gray4), 96'd0);
      check_eq("mr_av",    96'(avg_valid), 96'd0);
      acc(1'b1, 1'b0, 15'd4, 96'd0);
      check_eq("rs4_dout", dout, stream_word(4));
      check_eq("rs4_dv",   96'(dout_valid), 96'd1);
      check_eq("rs4_av",   96'(avg_valid), 96'd0);
      for (int i = 5; i < 10; i++) begin
         acc(1'b1, 1'b0, 15'(i), 96'd0);
         check_eq("rs_dout",  dout, stream_word(i));
         check_eq("rs_avg",   96'(avg), 96'(stream_avg(i - 1)));
         check_eq("rs_gray4", 96'(gray4), 96'(stream_avg(i - 1) / 16));
         check_eq("rs_av",    96'(avg_valid), 96'd1);
      end
      acc(1'b0, 1'b0, 15'd0, 96'd0);
      check_eq("end_avg", 96'(avg), 96'(stream_avg(9)));
      check_eq("end_dv",  96'(dout_valid), 96'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
